alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 2, number of clk cycles the controller waits for an ALU result when the select code is 2 (multiply); legal range 1..7.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester N operation accepted this cycle when valid and ready are both high.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8  operands of requester N.
REQ-007 req0_sel / req1_sel  input  4  ALU select code of requester N (0 add, 1 sub, 2 mul, 3 div, 4..15 shift/rotate/logic/compare).
REQ-008 rsp0_valid / rsp1_valid  output  1  result available for requester N.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes its result.
REQ-010 rsp0_out, rsp0_carry / rsp1_out, rsp1_carry  output  8 / 1  result and carry for requester N.
REQ-011 alu_a, alu_b  output  8  operands driven to the shared ALU.
REQ-012 alu_sel  output  4  select code driven to the shared ALU.
REQ-013 alu_out  input  8  ALU registered result; alu_carry  input  1  ALU carry-out.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on accepted request, EXEC->RESP when the wait counter expires, RESP->IDLE when the granted requester's rsp_valid and rsp_ready are both high.
REQ-016 In IDLE, exactly one reqN_ready SHALL be high, combinationally, for the granted requester; both ready low in EXEC and RESP.
REQ-017 Grant: only one valid -> that requester; both valid -> the requester not granted last (round-robin); pointer updates only on an accepted request.
REQ-018 On acceptance, a, b, sel and grant id SHALL be latched; alu_a/alu_b/alu_sel SHALL be driven from the latch and held stable through EXEC and RESP until the next acceptance.
REQ-019 EXEC wait SHALL be 1 cycle for sel != 2 and MUL_LAT cycles for sel == 2; on the last EXEC cycle edge, alu_out and alu_carry SHALL be captured into the result register.
REQ-020 Minimum issue-to-issue spacing SHALL be 3 cycles for single-cycle ops (accept, EXEC, RESP with rsp_ready high).
REQ-021 In RESP, rspN_valid SHALL be high only for the granted requester and held, with stable rspN_out/rspN_carry, until rspN_ready; the other requester's rsp signals are 0.
REQ-022 rsp_carry SHALL pass alu_carry unmodified for all select codes; the controller performs no arithmetic.
REQ-023 A request arriving in EXEC/RESP SHALL wait (ready low) and never be dropped; the requester holds valid and payload.

Reset
REQ-024 On rst_n low: state IDLE, round-robin pointer favours req0, wait counter 0, alu_a/alu_b/alu_sel 0, result register 0, all rsp_valid 0, busy 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no response delivered; after release the block accepts new requests in the first cycle.

Configuration
REQ-026 Macro ALU_ARB_CNT_EN defined: outputs done0_cnt and done1_cnt (16 bits each) count completed responses per requester, reset to 0, wrap from 0xFFFF to 0; undefined: ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-027 req0 only, a=200, b=100, sel=0 -> accepted cycle 0, rsp0_valid cycle 2, rsp0_out=44, rsp0_carry=1.
REQ-028 req0 and req1 valid together, sel=8, from reset -> req0 granted first, req1 granted on the next IDLE; repeated contention alternates 0,1,0,1.
REQ-029 req1 a=15, b=17, sel=2, MUL_LAT=2 -> rsp1_valid 3 cycles after acceptance, rsp1_out=255 (low byte of 255).
REQ-030 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp0_out stable, req0/req1 ready low, busy high throughout.
REQ-031 rst_n pulsed low during EXEC -> no rsp_valid, all outputs at reset values, new request accepted in the cycle after release.
REQ-032 ALU_ARB_CNT_EN defined, 3 req0 and 2 req1 completions -> done0_cnt=3, done1_cnt=2.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin two-requester front end for one shared ALU (IDLE/EXEC/RESP).
//            Optional ALU_ARB_CNT_EN adds per-requester completed-response counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [3:0] req0_sel,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [3:0] req1_sel,
   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic [7:0] rsp0_out,
   output logic       rsp0_carry,
   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [7:0] rsp1_out,
   output logic       rsp1_carry,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_out,
   input  logic       alu_carry,
`ifdef ALU_ARB_CNT_EN
   output logic [15:0] done0_cnt,
   output logic [15:0] done1_cnt,
`endif
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] c_MUL_WAIT = 3'(MUL_LAT - 1);
   localparam logic [3:0] c_SEL_MUL  = 4'd2;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_rr_ptr;     // 1 = req1 wins the next contention
   logic       r_gnt_id;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [3:0] r_sel;
   logic [2:0] r_wait;
   logic [7:0] r_res;
   logic       r_carry;

   logic       w_gnt;
   logic       w_acc;
   logic       w_exec_last;
   logic       w_rsp_done;
   logic [7:0] w_a;
   logic [7:0] w_b;
   logic [3:0] w_sel;

   always_comb begin
      w_gnt = r_rr_ptr;
      if (req0_valid && !req1_valid) begin
         w_gnt = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         w_gnt = 1'b1;
      end
   end

   assign w_acc       = (r_state == S_IDLE) && (w_gnt ? req1_valid : req0_valid);
   assign w_exec_last = (r_state == S_EXEC) && (r_wait == 3'd0);
   assign w_rsp_done  = (r_state == S_RESP) && (r_gnt_id ? rsp1_ready : rsp0_ready);
   assign w_a         = w_gnt ? req1_a   : req0_a;
   assign w_b         = w_gnt ? req1_b   : req0_b;
   assign w_sel       = w_gnt ? req1_sel : req0_sel;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_acc)       w_state_nxt = S_EXEC;
         S_EXEC:  if (w_exec_last) w_state_nxt = S_RESP;
         S_RESP:  if (w_rsp_done)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= 1'b0;
         r_gnt_id <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_sel    <= '0;
         r_wait   <= '0;
         r_res    <= '0;
         r_carry  <= 1'b0;
      end else begin
         if (w_acc) begin
            r_rr_ptr <= ~w_gnt;
            r_gnt_id <= w_gnt;
            r_a      <= w_a;
            r_b      <= w_b;
            r_sel    <= w_sel;
            r_wait   <= (w_sel == c_SEL_MUL) ? c_MUL_WAIT : 3'd0;
         end else if ((r_state == S_EXEC) && (r_wait != 3'd0)) begin
            r_wait <= r_wait - 3'd1;
         end
         if (w_exec_last) begin
            r_res   <= alu_out;
            r_carry <= alu_carry;
         end
      end
   end

`ifdef ALU_ARB_CNT_EN
   logic [15:0] r_done0_cnt;
   logic [15:0] r_done1_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done0_cnt <= '0;
         r_done1_cnt <= '0;
      end else if (w_rsp_done) begin
         if (r_gnt_id) r_done1_cnt <= r_done1_cnt + 16'd1;
         else          r_done0_cnt <= r_done0_cnt + 16'd1;
      end
   end

   assign done0_cnt = r_done0_cnt;
   assign done1_cnt = r_done1_cnt;
`endif

   assign req0_ready = (r_state == S_IDLE) && !w_gnt;
   assign req1_ready = (r_state == S_IDLE) &&  w_gnt;
   assign rsp0_valid = (r_state == S_RESP) && !r_gnt_id;
   assign rsp1_valid = (r_state == S_RESP) &&  r_gnt_id;
   assign rsp0_out   = rsp0_valid ? r_res   : 8'd0;
   assign rsp0_carry = rsp0_valid ? r_carry : 1'b0;
   assign rsp1_out   = rsp1_valid ? r_res   : 8'd0;
   assign rsp1_carry = rsp1_valid ? r_carry : 1'b0;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_sel    = r_sel;
   assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] req0_sel, req1_sel;
   logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [7:0] rsp0_out, rsp1_out;
   logic       rsp0_carry, rsp1_carry;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [3:0] alu_sel;
   logic       alu_carry;
   logic       busy;
`ifdef ALU_ARB_CNT_EN
   logic [15:0] done0_cnt, done1_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_done0 = 0;
   int exp_done1 = 0;

   alu_arbiter #(.MUL_LAT(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sel   (req0_sel),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sel   (req1_sel),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_out   (rsp0_out),
      .rsp0_carry (rsp0_carry),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_out   (rsp1_out),
      .rsp1_carry (rsp1_carry),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_carry  (alu_carry),
`ifdef ALU_ARB_CNT_EN
      .done0_cnt  (done0_cnt),
      .done1_cnt  (done1_cnt),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural shared ALU: add, sub (borrow as carry), mul (carry = high byte nonzero), and, xor.
   always_comb begin
      logic [8:0]  w_sum;
      logic [15:0] w_prod;
      w_sum     = 9'd0;
      w_prod    = 16'd0;
      alu_out   = 8'd0;
      alu_carry = 1'b0;
      case (alu_sel)
         4'd0: begin w_sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = w_sum[7:0]; alu_carry = w_sum[8]; end
         4'd1: begin w_sum = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = w_sum[7:0]; alu_carry = w_sum[8]; end
         4'd2: begin w_prod = alu_a * alu_b; alu_out = w_prod[7:0]; alu_carry = |w_prod[15:8]; end
         4'd8: alu_out = alu_a & alu_b;
         default: alu_out = alu_a ^ alu_b;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op with both rsp_ready high; checks grant, latency, result and return to IDLE.
   task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input int exp_lat, input logic [7:0] exp_out, input logic exp_c);
      int cyc;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; end
      #1;
      check_eq("issue_ready", id ? req1_ready : req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check_eq("issue_busy", busy, 1);
      cyc = 1;
      while (!(id ? rsp1_valid : rsp0_valid) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("rsp_latency", cyc, exp_lat);
      check_eq("rsp_out", id ? rsp1_out : rsp0_out, exp_out);
      check_eq("rsp_carry", id ? rsp1_carry : rsp0_carry, exp_c);
      check_eq("rsp_other_valid", id ? rsp0_valid : rsp1_valid, 0);
      @(negedge clk);
      check_eq("back_idle", busy, 0);
      if (id) exp_done1++; else exp_done0++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_done0 = 0;
      exp_done1 = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk);
      do_reset();

      check_eq("rst_busy", busy, 0);
      check_eq("rst_rsp0_valid", rsp0_valid, 0);
      check_eq("rst_rsp1_valid", rsp1_valid, 0);
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_alu_sel", alu_sel, 0);
      check_eq("rst_req0_ready", req0_ready, 1);
      check_eq("rst_req1_ready", req1_ready, 0);

      // 200 + 100 = 300 -> 44 with carry
      issue(1'b0, 8'd200, 8'd100, 4'd0, 2, 8'd44, 1'b1);
      // 15 * 17 = 255, MUL_LAT 2 -> response 3 cycles after acceptance
      issue(1'b1, 8'd15, 8'd17, 4'd2, 3, 8'd255, 1'b0);

      // Response back-pressure while req1 waits
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd3; req0_sel = 4'd1;
      #1;
      check_eq("hold_accept", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd2; req1_sel = 4'd0;
      #1;
      check_eq("hold_exec_alu_a", alu_a, 8'd10);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check_eq("hold_rsp0_valid", rsp0_valid, 1);
         check_eq("hold_rsp0_out", rsp0_out, 8'd7);
         check_eq("hold_req0_ready", req0_ready, 0);
         check_eq("hold_req1_ready", req1_ready, 0);
         check_eq("hold_busy", busy, 1);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      exp_done0++;
      @(negedge clk);
      #1;
      check_eq("waiting_req1_ready", req1_ready, 1);
      check_eq("waiting_rsp0_valid", rsp0_valid, 0);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      check_eq("waiting_rsp1_valid", rsp1_valid, 1);
      check_eq("waiting_rsp1_out", rsp1_out, 8'd3);
      exp_done1++;
      @(negedge clk);
      check_eq("waiting_idle", busy, 0);

      // Reset pulse during EXEC aborts the op
      req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd6; req0_sel = 4'd0;
      @(negedge clk);
      req0_valid = 1'b0;
      check_eq("abort_in_exec", busy, 1);
      rst_n = 1'b0;
      exp_done0 = 0;
      exp_done1 = 0;
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_alu_a", alu_a, 0);
      check_eq("abort_alu_b", alu_b, 0);
      check_eq("abort_rsp0_valid", rsp0_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("abort_no_rsp", rsp0_valid, 0);
      issue(1'b1, 8'd1, 8'd1, 4'd0, 2, 8'd2, 1'b0);

      // Contention from reset alternates 0,1,0,1
      do_reset();
      req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_sel = 4'd8;
      req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h3C; req1_sel = 4'd8;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("rr_req0_ready", req0_ready, (i % 2) == 0);
         check_eq("rr_req1_ready", req1_ready, (i % 2) == 1);
         @(negedge clk);
         @(negedge clk);
         check_eq("rr_rsp0_valid", rsp0_valid, (i % 2) == 0);
         check_eq("rr_rsp1_valid", rsp1_valid, (i % 2) == 1);
         check_eq("rr_out", (i % 2) ? rsp1_out : rsp0_out, 8'h30);
         if (i % 2) exp_done1++; else exp_done0++;
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      issue(1'b0, 8'd3, 8'd5, 4'd6, 2, 8'd6, 1'b0);

`ifdef ALU_ARB_CNT_EN
      check_eq("done0_cnt", done0_cnt, 32'(exp_done0));
      check_eq("done1_cnt", done1_cnt, 32'(exp_done1));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
